uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of two, at least 2.
REQ-002 SHALL have parameter THRESH, default 8, fill level at or above which the threshold interrupt asserts; range 1..DEPTH.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096, number of idle cycles before the timeout flag sets; only used when UART_RX_FIFO_TIMEOUT_EN is defined.
REQ-004 SHALL have ports:
 - clk  in  1  sole clock, rising edge.
 - rst  in  1  asynchronous, active-low reset.
 - rx_end  in  1  one-cycle pulse from the UART receiver: byte complete.
 - rx_data  in  8  received byte, sampled when rx_end=1.
 - rd_valid  out  1  FIFO non-empty.
 - rd_data  out  8  head entry, valid while rd_valid=1.
 - rd_ready  in  1  consumer accepts the head entry.
 - level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
 - overrun  out  1  sticky flag: a byte was dropped.
 - clr_overrun  in  1  synchronous clear of overrun.
 - irq  out  1  combined interrupt, level-sensitive.

Function
REQ-005 SHALL push rx_data at the clk edge where rx_end=1 and the FIFO is not full, or is full with a pop in the same cycle.
REQ-006 SHALL pop the head at the clk edge where rd_valid=1 and rd_ready=1.
REQ-007 SHALL present rd_data first-word-fall-through: a byte pushed at edge N is on rd_data with rd_valid=1 from edge N onward. There is no same-cycle bypass when empty; rd_valid stays 0 in the push cycle itself.
REQ-008 SHALL drop the byte and set overrun at the edge where rx_end=1, the FIFO is full, and no pop occurs; level and FIFO contents are unchanged.
REQ-009 SHALL keep level unchanged on a simultaneous push and pop, including the full and non-empty cases.
REQ-010 SHALL wrap read and write pointers modulo DEPTH. Full is level==DEPTH; empty is level==0.
REQ-011 SHALL clear overrun on clr_overrun=1 at the edge. If a set condition and clr_overrun coincide, set wins.
REQ-012 SHALL drive irq = (level >= THRESH) | overrun | timeout_flag; timeout_flag is 0 when the timeout feature is compiled out.
REQ-013 SHALL ignore rd_ready when empty; a pop from empty never occurs and never changes level.
REQ-014 SHALL preserve FIFO order exactly; no byte is duplicated or reordered.

Reset
REQ-015 SHALL, while rst=0, immediately force the following, regardless of clk: level=0, rd_valid=0, pointers=0, overrun=0, timeout counter=0, timeout_flag=0, irq=0.
REQ-016 SHALL define rd_data as 8'h00 under reset; memory contents are not cleared.
REQ-017 SHALL, on reset asserted mid-operation, discard all stored bytes; the first rx_end after release is stored at entry 0.

Configuration
REQ-018 SHALL implement the idle timeout only when macro UART_RX_FIFO_TIMEOUT_EN is defined.
 - With the macro: a counter increments each cycle while level>0 and neither push nor pop occurs, and resets to 0 on any push, pop, or level==0.
 - timeout_flag sets when the counter reaches TIMEOUT_CYC-1 and clears on the next push or pop, or when level==0.
 - The counter saturates; it does not wrap.
REQ-019 SHALL, without the macro, contain no timeout counter or flag; irq is threshold | overrun only.

Verification
REQ-020 Single byte: reset, rx_end with 8'hA5, rd_ready=0 -> rd_valid=1, rd_data=8'hA5, level=1 from the next cycle; pulse rd_ready -> level=0, rd_valid=0.
REQ-021 Fill and overrun (DEPTH=16): 17 rx_end pulses with bytes 0x00..0x10, rd_ready=0 -> level=16, overrun=1, irq=1. Draining 16 bytes reads 0x00..0x0F; 0x10 is lost.
REQ-022 Full with simultaneous push and pop: FIFO full, rx_end with 8'h77 and rd_ready=1 in the same cycle -> level stays 16, overrun stays 0, 8'h77 is read last.
REQ-023 Threshold and clear: push 7 bytes -> irq=0; 8th byte -> irq=1; pop one -> irq=0. Overrun set with clr_overrun=1 in the same cycle -> overrun=1; clr_overrun alone next cycle -> overrun=0.
REQ-024 Timeout (macro defined, TIMEOUT_CYC=16): push 1 byte, then idle -> timeout_flag and irq=1 exactly 16 cycles after the push edge; a pop clears it. Macro undefined -> irq stays 0 indefinitely.
REQ-025 Reset mid-operation: 5 bytes stored, rst=0 asynchronously between clk edges -> level=0, rd_valid=0, irq=0 immediately. After release, push 8'h3C -> rd_data=8'h3C.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: first-word-fall-through read port, sticky overrun,
// level-threshold interrupt. Define UART_RX_FIFO_TIMEOUT_EN to add the idle-timeout interrupt.
module uart_rx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned THRESH      = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_end,
    input  logic [7:0]               rx_data,
    output logic                     rd_valid,
    output logic [7:0]               rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic                     irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          overrun_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic          timeout_flag;

    assign full     = (level_q == LW'(DEPTH));
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = rx_end && (!full || pop);
    assign drop     = rx_end && full && !pop;

    // Level is zero under reset, so gating on rd_valid also yields 8'h00 there.
    assign rd_data  = rd_valid ? mem[rd_ptr_q] : 8'h00;
    assign level    = level_q;
    assign overrun  = overrun_q;
    assign irq      = (level_q >= LW'(THRESH)) | overrun_q | timeout_flag;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] tmo_cnt_q;
    logic          timeout_flag_q;
    logic          idle;

    assign idle         = rd_valid && !push && !pop;
    assign timeout_flag = timeout_flag_q;

    // Counter parks at TIMEOUT_CYC-1; the flag then sets on the following idle edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else if (!idle) begin
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else if (tmo_cnt_q != CW'(TIMEOUT_CYC - 1)) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end else begin
            timeout_flag_q <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign timeout_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_CYC=16).
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [4:0] level;
    logic       overrun;
    logic       clr_overrun;
    logic       irq;

    int tests = 0;
    int fails = 0;

    uart_rx_fifo #(
        .DEPTH      (16),
        .THRESH     (8),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_end     (rx_end),
        .rx_data    (rx_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .level      (level),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_end  = 1'b1;
        rx_data = b;
        tick();
        rx_end  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rx_end = 1'b0; rx_data = 8'h00; rd_ready = 1'b0; clr_overrun = 1'b0;
        #2;
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 8'h00);
        chk("rst_ovr", overrun, 0);
        chk("rst_irq", irq, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single byte, no same-cycle bypass
        rx_end = 1'b1; rx_data = 8'hA5;
        #1;
        chk("single_nobypass", rd_valid, 0);
        tick();
        rx_end = 1'b0;
        chk("single_valid", rd_valid, 1);
        chk("single_data", rd_data, 8'hA5);
        chk("single_level", level, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_pop_level", level, 0);
        chk("single_pop_valid", rd_valid, 0);
        // rd_ready on empty must not underflow
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("empty_pop_level", level, 0);

        // Fill and overrun
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_level", level, 16);
        chk("fill_ovr0", overrun, 0);
        chk("fill_irq", irq, 1);
        push(8'h10);
        chk("ovr_level", level, 16);
        chk("ovr_set", overrun, 1);
        chk("ovr_irq", irq, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain1_%0d", i), rd_data, i);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("drain1_level", level, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        rx_end = 1'b1; rx_data = 8'h77; rd_ready = 1'b1;
        tick();
        rx_end = 1'b0; rd_ready = 1'b0;
        chk("pp_level", level, 16);
        chk("pp_ovr", overrun, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain2_%0d", i), rd_data, (i < 15) ? 32'h21 + i : 32'h77);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        chk("drain2_level", level, 0);

        // Threshold boundary and overrun set-vs-clear priority
        for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
        chk("thr_7", irq, 0);
        push(8'h47);
        chk("thr_8", irq, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("thr_pop", irq, 0);
        chk("thr_pop_level", level, 7);
        for (int i = 0; i < 9; i++) push(8'h50 + 8'(i));
        chk("thr_full", level, 16);
        rx_end = 1'b1; rx_data = 8'hEE; clr_overrun = 1'b1;
        tick();
        rx_end = 1'b0;
        chk("set_wins", overrun, 1);
        tick();
        clr_overrun = 1'b0;
        chk("clr_alone", overrun, 0);
        chk("thr_head", rd_data, 8'h41);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        rd_ready = 1'b0;
        chk("thr_drain_level", level, 0);

        // Idle timeout
        push(8'h11);
`ifdef UART_RX_FIFO_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            chk($sformatf("tmo_early_%0d", k), irq, 0);
        end
        tick();
        chk("tmo_fire", irq, 1);
        tick();
        chk("tmo_hold", irq, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("tmo_pop_clr", irq, 0);
`else
        for (int k = 0; k < 40; k++) tick();
        chk("no_tmo_irq", irq, 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("no_tmo_pop", irq, 0);
`endif
        chk("tmo_level", level, 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        chk("pre_rst_level", level, 5);
        chk("pre_rst_valid", rd_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_irq", irq, 0);
        chk("arst_data", rd_data, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        push(8'h3C);
        chk("post_rst_data", rd_data, 8'h3C);
        chk("post_rst_level", level, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
